// File: rtl/accumulating_adder.sv
// Streaming accumulator: sums COUNT unsigned WIDTH-bit operands into one registered result.
// Optional synchronous partial-sum clear input enabled by ACCUMULATING_ADDER_CLEAR_EN.
module accumulating_adder #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned COUNT = 8,
  localparam int unsigned SUM_WIDTH = WIDTH + $clog2(COUNT)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
`ifdef ACCUMULATING_ADDER_CLEAR_EN
  input  logic                 clear_i,
`endif
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     a_i,
  output logic [SUM_WIDTH-1:0] sum_o,
  output logic                 sum_valid_o,
  input  logic                 sum_ready_i
);

  localparam int unsigned CntWidth = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(COUNT - 1);

  typedef enum logic {StAccum, StHold} state_e;

  state_e               state_q, state_d;
  logic [SUM_WIDTH-1:0] acc_q, acc_d;
  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [SUM_WIDTH-1:0] addend;
  logic [SUM_WIDTH-1:0] acc_sum;
  logic                 clear_acc;
  logic                 take;
  logic                 last;

`ifdef ACCUMULATING_ADDER_CLEAR_EN
  // A finished result is never discarded, so clear only acts while accumulating.
  assign clear_acc = clear_i && (state_q == StAccum);
`else
  assign clear_acc = 1'b0;
`endif

  assign in_ready_o  = (state_q == StAccum) || sum_ready_i;
  assign take        = in_valid_i && in_ready_o && !clear_acc;
  // Gating by take keeps an undriven operand out of the accumulator.
  assign addend      = take ? SUM_WIDTH'(a_i) : '0;
  assign last        = (cnt_q == CntLast);
  assign sum_o       = sum_q;
  assign sum_valid_o = (state_q == StHold);

  always_comb begin
    logic carry;
    carry   = 1'b0;
    acc_sum = '0;
    for (int i = 0; i < int'(SUM_WIDTH); i++) begin
      acc_sum[i] = acc_q[i] ^ addend[i] ^ carry;
      carry      = (acc_q[i] & addend[i]) | (carry & (acc_q[i] ^ addend[i]));
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    unique case (state_q)
      StAccum: begin
        if (clear_acc) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (take) begin
          if (last) begin
            sum_d   = acc_sum;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StHold;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CntWidth'(1);
          end
        end
      end
      StHold: begin
        // The accumulator is already empty here, so an operand starts the next group.
        if (sum_ready_i) begin
          state_d = StAccum;
          if (take) begin
            if (last) begin
              sum_d   = acc_sum;
              state_d = StHold;
            end else begin
              acc_d = acc_sum;
              cnt_d = cnt_q + CntWidth'(1);
            end
          end
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StAccum;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_accumulating_adder.sv
// Self-checking bench: four accumulating_adder configurations against a queue-based model.
module tb_accumulating_adder;

  localparam int NCfg = 4;

  function automatic int cfg_w(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int cfg_c(input int g);
    case (g)
      0:       return 8;
      1:       return 8;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clear;
  logic [NCfg-1:0]      in_valid;
  logic [NCfg-1:0]      sum_ready;
  logic [NCfg-1:0]      in_ready;
  logic [NCfg-1:0]      sum_valid;
  logic [NCfg-1:0][7:0] a_all;
  logic [NCfg-1:0][7:0] sum_all;

  int n_checks;
  int n_fail;
  int nbr_bits [8] = '{1, 0, 1, 1, 0, 0, 1, 0};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < NCfg; g++) begin : gen_cfg
    localparam int W  = cfg_w(g);
    localparam int C  = cfg_c(g);
    localparam int SW = W + $clog2(C);

    logic [SW-1:0] sum_w;
    logic          rdy_w;
    logic          vld_w;

    accumulating_adder #(
      .WIDTH(W),
      .COUNT(C)
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
`ifdef ACCUMULATING_ADDER_CLEAR_EN
      .clear_i    (clear),
`endif
      .in_valid_i (in_valid[g]),
      .in_ready_o (rdy_w),
      .a_i        (a_all[g][W-1:0]),
      .sum_o      (sum_w),
      .sum_valid_o(vld_w),
      .sum_ready_i(sum_ready[g])
    );

    assign sum_all[g]   = 8'(sum_w);
    assign in_ready[g]  = rdy_w;
    assign sum_valid[g] = vld_w;

    // Model: operands of the open group, and completed results awaiting consumption.
    int ops[$];
    int res[$];

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        ops.delete();
        res.delete();
      end else begin
        automatic bit hold = (res.size() != 0);
        automatic bit clr  = 1'b0;
        automatic int total = 0;
`ifdef ACCUMULATING_ADDER_CLEAR_EN
        clr = clear && !hold;
`endif
        if (hold && sum_ready[g]) void'(res.pop_front());
        if (clr) begin
          ops.delete();
        end else if (in_valid[g] && (!hold || sum_ready[g])) begin
          ops.push_back(int'(a_all[g][W-1:0]));
          if (ops.size() == C) begin
            foreach (ops[i]) total += ops[i];
            res.push_back(total);
            ops.delete();
          end
        end
      end
    end

    always @(negedge clk) begin
      #4;
      if (!rst) begin
        check($sformatf("cfg%0d sum_valid", g), 32'(sum_valid[g]), 32'(res.size() != 0));
        check($sformatf("cfg%0d in_ready", g), 32'(in_ready[g]),
              32'((res.size() == 0) || sum_ready[g]));
        if (res.size() != 0) check($sformatf("cfg%0d sum", g), 32'(sum_all[g]), res[0]);
      end
    end
  end

  task automatic cyc_in(input int k, input bit v, input int val, input bit rdy);
    @(negedge clk);
    clear        = 1'b0;
    in_valid[k]  = v;
    a_all[k]     = 8'(val);
    sum_ready[k] = rdy;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    in_valid  = '0;
    sum_ready = '1;
    clear     = 1'b0;
    a_all     = '0;
    rst       = 1'b1;
    #12;
    for (int k = 0; k < NCfg; k++) begin
      check("reset in_ready", 32'(in_ready[k]), 1);
      check("reset sum_valid", 32'(sum_valid[k]), 0);
      check("reset sum", 32'(sum_all[k]), 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Neighbour count
    foreach (nbr_bits[i]) cyc_in(0, 1'b1, nbr_bits[i], 1'b1);
    after_edge();
    check("nbr sum", 32'(sum_all[0]), 4);
    check("nbr valid", 32'(sum_valid[0]), 1);
    cyc_in(0, 1'b0, 0, 1'b1);
    after_edge();
    check("nbr valid one cycle", 32'(sum_valid[0]), 0);

    // Maximum value, no wrap
    repeat (8) cyc_in(1, 1'b1, 3, 1'b1);
    after_edge();
    check("max sum", 32'(sum_all[1]), 24);
    cyc_in(1, 1'b0, 0, 1'b1);

    // Backpressure
    cyc_in(2, 1'b1, 1, 1'b1);
    cyc_in(2, 1'b1, 2, 1'b1);
    cyc_in(2, 1'b1, 3, 1'b1);
    cyc_in(2, 1'b1, 0, 1'b0);
    repeat (5) begin
      cyc_in(2, 1'b0, 0, 1'b0);
      #1;
      check("bp sum stable", 32'(sum_all[2]), 6);
      check("bp in_ready low", 32'(in_ready[2]), 0);
    end
    cyc_in(2, 1'b1, 2, 1'b1);
    after_edge();
    check("bp consumed", 32'(sum_valid[2]), 0);
    repeat (3) cyc_in(2, 1'b1, 1, 1'b1);
    after_edge();
    check("bp carried term", 32'(sum_all[2]), 5);
    cyc_in(2, 1'b0, 0, 1'b1);

    // COUNT=1 with gaps, then streaming
    cyc_in(3, 1'b1, 5, 1'b1);
    after_edge();
    check("c1 first", 32'(sum_all[3]), 5);
    repeat (3) cyc_in(3, 1'b0, 0, 1'b1);
    cyc_in(3, 1'b1, 7, 1'b1);
    after_edge();
    check("c1 second", 32'(sum_all[3]), 7);
    for (int v = 1; v <= 4; v++) begin
      cyc_in(3, 1'b1, v, 1'b1);
      after_edge();
      check("c1 stream sum", 32'(sum_all[3]), 32'(v));
      check("c1 stream valid", 32'(sum_valid[3]), 1);
    end
    cyc_in(3, 1'b0, 0, 1'b1);

    // Async reset with one instance mid-group and another holding a result
    repeat (3) cyc_in(2, 1'b1, 1, 1'b1);
    cyc_in(2, 1'b1, 1, 1'b0);
    cyc_in(2, 1'b0, 0, 1'b0);
    repeat (5) cyc_in(0, 1'b1, 1, 1'b1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst valid mid", 32'(sum_valid[0]), 0);
    check("arst ready mid", 32'(in_ready[0]), 1);
    check("arst valid hold", 32'(sum_valid[2]), 0);
    check("arst ready hold", 32'(in_ready[2]), 1);
    check("arst sum hold", 32'(sum_all[2]), 0);
    @(negedge clk);
    rst          = 1'b0;
    sum_ready[2] = 1'b1;
    repeat (8) cyc_in(0, 1'b1, 1, 1'b1);
    after_edge();
    check("arst fresh sum", 32'(sum_all[0]), 8);
    cyc_in(0, 1'b0, 0, 1'b1);

`ifdef ACCUMULATING_ADDER_CLEAR_EN
    cyc_in(2, 1'b1, 3, 1'b1);
    cyc_in(2, 1'b1, 3, 1'b1);
    cyc_in(2, 1'b1, 3, 1'b1);
    clear = 1'b1;
    repeat (4) cyc_in(2, 1'b1, 1, 1'b1);
    after_edge();
    check("clear sum", 32'(sum_all[2]), 4);
    cyc_in(2, 1'b0, 0, 1'b0);
    clear = 1'b1;
    after_edge();
    check("clear in hold sum", 32'(sum_all[2]), 4);
    check("clear in hold valid", 32'(sum_valid[2]), 1);
    cyc_in(2, 1'b0, 0, 1'b1);
`endif

    // Randomized traffic on all configurations
    repeat (1500) begin
      @(negedge clk);
      clear = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < NCfg; k++) begin
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        sum_ready[k] = ($urandom_range(0, 3) != 0);
        a_all[k]     = in_valid[k] ? 8'($urandom) : 'x;
      end
    end
    @(negedge clk);
    in_valid  = '0;
    sum_ready = '1;
    clear     = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/accumulating_adder.md
# accumulating_adder

- Sums a stream of COUNT unsigned WIDTH-bit operands into one SUM_WIDTH-bit result, with valid/ready handshakes on input and output.
- Parametrised, sequential successor to the fixed 2-bit combinational adder.
- Used for Conway neighbour counting (WIDTH=1, COUNT=8 gives a 0..8 live-neighbour count) and for wider partial-sum reduction.
- The datapath is a SUM_WIDTH-bit ripple chain of FULL_ADDER cells feeding an accumulator register.

## Interface

- WIDTH, 2: operand width in bits; must be ≥ 1.
- COUNT, 8: operands per result; must be ≥ 1.
- SUM_WIDTH: derived localparam, not overridable; equals WIDTH + $clog2(COUNT), which is WIDTH when COUNT=1.
- CLK  input  1: sole clock, rising edge.
- RST  input  1: reset, asynchronous and active-high.
- IN_VALID  input  1: A carries a valid operand.
- IN_READY  output  1: block accepts an operand this cycle.
- A  input  WIDTH: operand, unsigned.
- SUM  output  SUM_WIDTH: completed sum, unsigned, registered.
- SUM_VALID  output  1: SUM holds a completed result.
- SUM_READY  input  1: consumer accepts SUM this cycle.
- CLEAR  input  1: present only with ACCUMULATING_ADDER_CLEAR_EN.

## Operation

- Two-state FSM: ACCUM and HOLD.
- Internal registers: accumulator ACC (SUM_WIDTH bits) and operand counter CNT (max(1, $clog2(COUNT)) bits).
- An operand is accepted on a cycle where IN_VALID && IN_READY.
- ACCUM state:
  - IN_READY=1 and SUM_VALID=0.
  - Accepting an operand while CNT < COUNT-1: ACC ← ACC + zext(A) and CNT ← CNT+1.
  - Accepting an operand while CNT == COUNT-1: SUM ← ACC + zext(A), ACC ← 0, CNT ← 0, and the FSM moves to HOLD.
- HOLD state:
  - SUM_VALID=1 and IN_READY = SUM_READY, which is combinational.
  - SUM_READY=0: hold everything; SUM stays stable.
  - SUM_READY=1 with no operand: return to ACCUM.
  - SUM_READY=1 with an operand accepted: behave as ACCUM on an empty accumulator. The operand becomes the first term (ACC ← zext(A), CNT ← 1). When COUNT=1, SUM ← zext(A) and the FSM stays in HOLD.
- Arithmetic:
  - Unsigned, with operands zero-extended to SUM_WIDTH.
  - Overflow cannot occur, because COUNT·(2^WIDTH−1) < 2^SUM_WIDTH.
  - No carry-out or overflow port.
- IN_VALID=0 cycles in ACCUM leave ACC and CNT unchanged; gaps are allowed anywhere in the stream.
- A is don't-care when IN_VALID=0. X on A must not propagate into ACC.

## Timing

- Reset (RST high, asynchronous):
  - State ACCUM, ACC=0, CNT=0, SUM=0, SUM_VALID=0.
  - IN_READY=1 while in reset and after release.
- Reset mid-accumulation discards the partial sum. Reset in HOLD drops SUM_VALID immediately, without waiting for a clock.
- Latency: SUM_VALID rises on the clock edge that accepts the COUNT-th operand.
- Throughput:
  - Back-to-back streaming with SUM_READY held high gives one result per COUNT cycles, with no bubble.
  - Each cycle SUM_READY is low in HOLD stalls the input by one cycle.
- SUM and SUM_VALID are flop outputs.
- IN_READY is combinational only from SUM_READY, and only in HOLD.
- Once SUM_VALID is high, SUM must not change until it is consumed.

## Configuration

- Macro: ACCUMULATING_ADDER_CLEAR_EN.
- Defined:
  - Adds the CLEAR input (1 bit, synchronous, active-high).
  - In ACCUM, CLEAR forces ACC ← 0 and CNT ← 0 and ignores any operand that cycle. IN_READY stays 1; the operand is simply dropped.
  - In HOLD, CLEAR has no effect: a completed result is never discarded.
  - RST has priority over CLEAR.
- Undefined: the port is absent and the partial sum can only be discarded by RST.

## Test plan

- Neighbour count (WIDTH=1, COUNT=8): stream bits 1,0,1,1,0,0,1,0 with SUM_READY=1 → SUM=4 with SUM_VALID high for exactly one cycle, on the edge accepting the 8th bit.
- Maximum value (WIDTH=2, COUNT=8): eight operands of 3 → SUM=24 (5'b11000), with no wrap.
- Backpressure (WIDTH=2, COUNT=4): inputs 1,2,3,0, then hold SUM_READY=0 for 5 cycles → SUM=6 stable, IN_READY=0 throughout. Then raise SUM_READY with IN_VALID=1, A=2 → result consumed, next ACC=2, CNT=1.
- Gaps and COUNT=1 (WIDTH=3): inputs 5 and 7 with 3 idle cycles between → SUM=5 then SUM=7. Under continuous valid with SUM_READY=1, one result per cycle.
- Async reset (WIDTH=1, COUNT=8): assert RST mid-cycle after 5 operands → SUM_VALID=0 and IN_READY=1 immediately. Then 8 ones → SUM=8, with no residue from before the reset.
- CLEAR (ACCUMULATING_ADDER_CLEAR_EN, WIDTH=2, COUNT=4): inputs 3,3, then CLEAR with A=3, then 1,1,1,1 → SUM=4. CLEAR asserted in HOLD leaves SUM unchanged.
